nf10_rx_stamper: RTL and testbench
==================================

# nf10_rx_stamper

Inline AXI4-Stream stage that writes the free-running 64-bit `STAMP_COUNTER` from nf10_timestamp into the TUSER sideband of the first beat of every packet. It sits on the receive path between a port's RX queue output and the input arbiter, so every packet carries its arrival time to downstream logic and the host. Data passes through a 2-entry skid buffer with one cycle of latency and full one-beat-per-cycle throughput. The block also keeps a count of stamped packets.

## Interface
Parameters:
- `C_AXIS_DATA_WIDTH`, 256: TDATA width in bits.
- `C_AXIS_TUSER_WIDTH`, 128: TUSER width in bits.
- `TIMESTAMP_WIDTH`, 64: width of the stamp. Must match nf10_timestamp.
- `STAMP_LSB`, 32: lowest TUSER bit of the stamp field. The field is TUSER[STAMP_LSB+TIMESTAMP_WIDTH-1:STAMP_LSB]. Bits [31:0] (length/src/dst) are never touched.

Ports:
- `S_AXI_ACLK`  in  1: the single clock, shared with nf10_timestamp.
- `S_AXI_ARESETN`  in  1: asynchronous, active-low reset.
- `STAMP_COUNTER`  in  TIMESTAMP_WIDTH: current time from nf10_timestamp.
- `STAMP_EN`  in  1: when 1, stamping is enabled. Sampled only on SOP beats.
- `S_AXIS_TDATA`  in  C_AXIS_DATA_WIDTH: input data.
- `S_AXIS_TSTRB`  in  C_AXIS_DATA_WIDTH/8: input byte strobes.
- `S_AXIS_TUSER`  in  C_AXIS_TUSER_WIDTH: input sideband.
- `S_AXIS_TVALID`  in  1: input handshake.
- `S_AXIS_TLAST`  in  1: input handshake.
- `S_AXIS_TREADY`  out  1: input backpressure.
- `M_AXIS_TDATA`, `M_AXIS_TSTRB`, `M_AXIS_TUSER`, `M_AXIS_TVALID`, `M_AXIS_TLAST`  out  (same widths as input): output stream.
- `M_AXIS_TREADY`  in  1: output backpressure.
- `STAMP_PKT_COUNT`  out  32: number of packets stamped since reset.

## Operation
- Input beat accepted = S_AXIS_TVALID & S_AXIS_TREADY. Output beat taken = M_AXIS_TVALID & M_AXIS_TREADY.
- Framing FSM, evaluated on accepted beats:
  - WAIT_SOP: accepted beat with TLAST=0 → IN_PKT. Accepted beat with TLAST=1 is a single-beat packet and the FSM stays in WAIT_SOP.
  - IN_PKT: accepted beat with TLAST=1 → WAIT_SOP.
  - The reset state is WAIT_SOP.
- Any beat accepted in WAIT_SOP is the SOP beat.
- SOP beat with STAMP_EN=1:
  - The stored TUSER stamp field is STAMP_COUNTER as sampled in the same cycle as acceptance, not the value at output time.
  - STAMP_PKT_COUNT increments by 1 and wraps from 0xFFFFFFFF to 0.
- SOP beat with STAMP_EN=0, and every non-SOP beat: TUSER passes through unchanged and the count is unchanged.
- TDATA, TSTRB and TLAST always pass through unchanged.
- Skid buffer:
  - 2-entry FIFO that preserves beat order.
  - Occupancy changes by +1 on accept only, -1 on take only, and 0 on accept and take together.
  - S_AXIS_TREADY = (occupancy < 2) & ready_q. ready_q is a flop that is 0 in reset and becomes 1 on the first edge after reset release.
  - M_AXIS_TVALID = (occupancy > 0). M_AXIS_* shows the head entry.
- Reset, including mid-packet: buffer emptied, FSM to WAIT_SOP, count cleared. The first beat accepted after reset is treated as SOP, even if upstream was mid-packet.

## Timing
- Reset values:
  - S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, STAMP_PKT_COUNT=0.
  - M_AXIS_TDATA, M_AXIS_TSTRB and M_AXIS_TUSER are all 0.
- Latency: a beat accepted at edge k is on M_AXIS with TVALID=1 after edge k, i.e. during cycle k+1.
- STAMP_PKT_COUNT updates at the same edge that accepts the SOP beat.
- Throughput: with M_AXIS_TREADY held at 1, the block sustains 1 beat per cycle with no bubbles.
- Stall: with M_AXIS_TREADY=0, at most 2 beats are accepted. S_AXIS_TREADY is 0 from the cycle after the second accept until a take occurs.
- When the buffer is full, a take at edge k makes S_AXIS_TREADY=1 during cycle k+1.
- Output stability: while M_AXIS_TVALID=1 and M_AXIS_TREADY=0, all M_AXIS_* outputs hold stable.
- STAMP_COUNTER wrap needs no handling; the field is a raw copy.

## Test plan
- Stamp a single-beat packet: reset, STAMP_EN=1, STAMP_COUNTER=0x0000_0000_0000_1234, one beat with TUSER=0x...0000_00AB_0102_0040 and TLAST=1, M_AXIS_TREADY=1 → one cycle later M_AXIS_TUSER[95:32]=0x1234, [31:0]=0x0102_0040, [127:96] unchanged, and STAMP_PKT_COUNT=1.
- Multi-beat packet: 4-beat packet while STAMP_COUNTER increments by 1 per cycle, SOP accepted while the counter is 100 → beat 0 stamp=100, beats 1-3 TUSER bit-identical to input, TLAST on beat 3 only.
- Backpressure: M_AXIS_TREADY=0 for 10 cycles during a 6-beat packet → exactly 2 beats accepted, then TREADY=0. After release, all 6 beats come out in order with no loss or duplication, and the stamp equals the counter at SOP accept, not at output.
- Stamping disabled: STAMP_EN=0 on the SOP of packet A, STAMP_EN=1 on packet B, back-to-back → A's TUSER is unchanged, B is stamped, and STAMP_PKT_COUNT ends at 1.
- Reset mid-packet: assert S_AXIS_TREADY stimulus... specifically, assert S_AXIS_ARESETN low for 1 cycle after 2 of 5 beats of a packet have been accepted → outputs go to their reset values immediately. S_AXIS_TREADY=1 on the first edge after release. The next accepted beat is stamped as SOP, and the count is 1.
- Counter wrap: preload the count by stamping 2^32 packets, or use a forced start value of 0xFFFFFFFF, then stamp one more packet → STAMP_PKT_COUNT=0.

Source files
------------

// File: rtl/nf10_rx_stamper.sv
// Receive-path AXI4-Stream stage: writes the arrival timestamp into the TUSER
// stamp field of each packet's first beat, through a 2-entry skid buffer.
module nf10_rx_stamper #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int TIMESTAMP_WIDTH    = 64,
  parameter int STAMP_LSB          = 32
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [TIMESTAMP_WIDTH-1:0]        STAMP_COUNTER,
  input  logic                              STAMP_EN,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [31:0]                       STAMP_PKT_COUNT
);

  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic {WAIT_SOP, IN_PKT} state_t;

  state_t                          state, state_nxt;
  logic                            ready_q;
  logic [1:0]                      occ;
  logic                            wr_ptr, rd_ptr;
  logic [C_AXIS_DATA_WIDTH-1:0]    mem_data [2];
  logic [STRB_W-1:0]               mem_strb [2];
  logic [C_AXIS_TUSER_WIDTH-1:0]   mem_user [2];
  logic                            mem_last [2];
  logic [31:0]                     stamp_cnt;
  logic                            accept, take, sop, do_stamp;
  logic [C_AXIS_TUSER_WIDTH-1:0]   user_in;

  assign S_AXIS_TREADY   = (occ < 2'd2) && ready_q;
  assign M_AXIS_TVALID   = (occ != 2'd0);
  assign accept          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign take            = M_AXIS_TVALID && M_AXIS_TREADY;
  assign sop             = (state == WAIT_SOP);
  assign do_stamp        = accept && sop && STAMP_EN;

  assign M_AXIS_TDATA    = mem_data[rd_ptr];
  assign M_AXIS_TSTRB    = mem_strb[rd_ptr];
  assign M_AXIS_TUSER    = mem_user[rd_ptr];
  assign M_AXIS_TLAST    = mem_last[rd_ptr];
  assign STAMP_PKT_COUNT = stamp_cnt;

  // The stamp is captured at acceptance so buffering delay never skews arrival time
  always_comb begin
    user_in = S_AXIS_TUSER;
    if (sop && STAMP_EN)
      user_in[STAMP_LSB +: TIMESTAMP_WIDTH] = STAMP_COUNTER;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        WAIT_SOP: if (!S_AXIS_TLAST) state_nxt = IN_PKT;
        IN_PKT:   if (S_AXIS_TLAST)  state_nxt = WAIT_SOP;
        default:  state_nxt = WAIT_SOP;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state     <= WAIT_SOP;
      ready_q   <= 1'b0;
      occ       <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      stamp_cnt <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_strb[i] <= '0;
        mem_user[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
      if (accept) begin
        mem_data[wr_ptr] <= S_AXIS_TDATA;
        mem_strb[wr_ptr] <= S_AXIS_TSTRB;
        mem_user[wr_ptr] <= user_in;
        mem_last[wr_ptr] <= S_AXIS_TLAST;
        wr_ptr           <= ~wr_ptr;
      end
      if (take)
        rd_ptr <= ~rd_ptr;
      case ({accept, take})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (do_stamp)
        stamp_cnt <= stamp_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_nf10_rx_stamper.sv
// Directed self-checking bench for nf10_rx_stamper: stamping, pass-through,
// backpressure, enable gating, mid-packet reset and count wrap.
module tb_nf10_rx_stamper;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  stamp_counter;
  logic         stamp_en;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid, s_tlast, s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid, m_tlast, m_tready;
  logic [31:0]  pkt_count;

  int           assert_count = 0;
  int           fail_count   = 0;
  bit           ts_run       = 0;
  int           idx, rcv;
  bit           acc, tk;
  logic [255:0] got_data [8];
  logic [127:0] got_user [8];
  logic         got_last [8];
  logic [127:0] exp_user;

  nf10_rx_stamper dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .STAMP_COUNTER   (stamp_counter),
    .STAMP_EN        (stamp_en),
    .S_AXIS_TDATA    (s_tdata),
    .S_AXIS_TSTRB    (s_tstrb),
    .S_AXIS_TUSER    (s_tuser),
    .S_AXIS_TVALID   (s_tvalid),
    .S_AXIS_TLAST    (s_tlast),
    .S_AXIS_TREADY   (s_tready),
    .M_AXIS_TDATA    (m_tdata),
    .M_AXIS_TSTRB    (m_tstrb),
    .M_AXIS_TUSER    (m_tuser),
    .M_AXIS_TVALID   (m_tvalid),
    .M_AXIS_TLAST    (m_tlast),
    .M_AXIS_TREADY   (m_tready),
    .STAMP_PKT_COUNT (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [255:0] d, input logic [127:0] u, input logic l);
    s_tdata  = d;
    s_tstrb  = d[31:0];
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (ts_run) stamp_counter = stamp_counter + 64'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stamp_counter = 64'd0; stamp_en = 1'b0;
    s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;
    tick();
    tick();
    checkOutput("reset s_tready", s_tready, 0);
    checkOutput("reset m_tvalid", m_tvalid, 0);
    checkOutput("reset m_tlast", m_tlast, 0);
    checkOutput("reset count", pkt_count, 0);
    checkOutput("reset m_tdata", m_tdata, 0);
    checkOutput("reset m_tuser", m_tuser, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("ready after release", s_tready, 1);

    // single-beat stamped packet
    stamp_en = 1'b1;
    stamp_counter = 64'h1234;
    applyStimulus({8{32'h1111_0001}}, 128'hDEADBEEF_00000000_000000AB_01020040, 1'b1);
    tick();
    checkOutput("single m_tvalid", m_tvalid, 1);
    checkOutput("single m_tuser", m_tuser, 128'hDEADBEEF_00000000_00001234_01020040);
    checkOutput("single m_tdata", m_tdata, {8{32'h1111_0001}});
    checkOutput("single m_tstrb", m_tstrb, 32'h1111_0001);
    checkOutput("single m_tlast", m_tlast, 1);
    checkOutput("single count", pkt_count, 1);
    s_tvalid = 1'b0;
    tick();
    checkOutput("single drained", m_tvalid, 0);

    // 4-beat packet, counter running, SOP accepted at counter 100
    stamp_counter = 64'd100;
    ts_run = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus({8{32'h2000_0000 + 32'(i)}},
                    {32'hA000_0000 + 32'(i), 64'h1111_2222_3333_4440 + 64'(i), 32'h0000_0100 + 32'(i)},
                    i == 3);
      tick();
      exp_user = {32'hA000_0000 + 32'(i), 64'h1111_2222_3333_4440 + 64'(i), 32'h0000_0100 + 32'(i)};
      if (i == 0) exp_user[95:32] = 64'd100;
      checkOutput($sformatf("multi%0d m_tvalid", i), m_tvalid, 1);
      checkOutput($sformatf("multi%0d m_tuser", i), m_tuser, exp_user);
      checkOutput($sformatf("multi%0d m_tdata", i), m_tdata, {8{32'h2000_0000 + 32'(i)}});
      checkOutput($sformatf("multi%0d m_tlast", i), m_tlast, (i == 3) ? 1 : 0);
    end
    s_tvalid = 1'b0;
    tick();
    checkOutput("multi count", pkt_count, 2);

    // 6-beat packet with 10 stalled cycles; SOP accepted at counter 500
    m_tready = 1'b0;
    stamp_counter = 64'd500;
    idx = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 10) m_tready = 1'b1;
      if (idx < 6)
        applyStimulus({8{32'hB000_0000 + 32'(idx)}},
                      {32'hC0DE_0000 + 32'(idx), 64'd0, 32'h0000_0040 + 32'(idx)}, idx == 5);
      else
        s_tvalid = 1'b0;
      acc = s_tvalid && s_tready;
      tk  = m_tvalid && m_tready;
      if (tk && rcv < 8) begin
        got_data[rcv] = m_tdata;
        got_user[rcv] = m_tuser;
        got_last[rcv] = m_tlast;
        rcv++;
      end
      tick();
      if (acc) idx++;
      if (cyc == 9) begin
        checkOutput("stall accepted", 256'(idx), 2);
        checkOutput("stall s_tready", s_tready, 0);
        checkOutput("stall hold tdata", m_tdata, {8{32'hB000_0000}});
        checkOutput("stall hold tuser", m_tuser, {32'hC0DE_0000, 64'd500, 32'h0000_0040});
      end
    end
    checkOutput("stall rx count", 256'(rcv), 6);
    for (int i = 0; i < 6; i++) begin
      exp_user = {32'hC0DE_0000 + 32'(i), 64'd0, 32'h0000_0040 + 32'(i)};
      if (i == 0) exp_user[95:32] = 64'd500;
      checkOutput($sformatf("stall beat%0d data", i), got_data[i], {8{32'hB000_0000 + 32'(i)}});
      checkOutput($sformatf("stall beat%0d user", i), got_user[i], exp_user);
      checkOutput($sformatf("stall beat%0d last", i), got_last[i], (i == 5) ? 1 : 0);
    end
    checkOutput("stall count", pkt_count, 3);

    // stamping disabled on A, enabled on B, back-to-back
    ts_run = 0;
    do_reset();
    stamp_counter = 64'd700;
    ts_run = 1;
    stamp_en = 1'b0;
    applyStimulus({8{32'h3000_000A}}, 128'h0000_AAAA_5555_5555_6666_6666_0000_0040, 1'b1);
    tick();
    checkOutput("enA m_tuser", m_tuser, 128'h0000_AAAA_5555_5555_6666_6666_0000_0040);
    checkOutput("enA count", pkt_count, 0);
    stamp_en = 1'b1;
    applyStimulus({8{32'h3000_000B}}, 128'h0000_BBBB_5555_5555_6666_6666_0000_0080, 1'b1);
    tick();
    checkOutput("enB m_tuser", m_tuser, 128'h0000_BBBB_0000_0000_0000_02BD_0000_0080);
    s_tvalid = 1'b0;
    tick();
    checkOutput("en count", pkt_count, 1);

    // reset after 2 of 5 beats
    for (int i = 0; i < 2; i++) begin
      applyStimulus({8{32'h4000_0000 + 32'(i)}}, {96'd0, 32'h0000_0200 + 32'(i)}, 1'b0);
      tick();
    end
    checkOutput("midrst pre count", pkt_count, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst m_tvalid", m_tvalid, 0);
    checkOutput("midrst s_tready", s_tready, 0);
    checkOutput("midrst count", pkt_count, 0);
    checkOutput("midrst m_tuser", m_tuser, 0);
    checkOutput("midrst m_tdata", m_tdata, 0);
    ts_run = 0;
    tick();
    rst_n = 1'b1;
    applyStimulus({8{32'h4000_0002}}, {96'd0, 32'h0000_0202}, 1'b0);
    tick();
    checkOutput("midrst ready", s_tready, 1);
    checkOutput("midrst no accept", m_tvalid, 0);
    stamp_counter = 64'h0ABC;
    tick();
    checkOutput("midrst sop m_tuser", m_tuser, {32'd0, 64'h0ABC, 32'h0000_0202});
    checkOutput("midrst sop count", pkt_count, 1);
    stamp_en = 1'b0;
    applyStimulus({8{32'h4000_0003}}, {96'd0, 32'h0000_0203}, 1'b1);
    tick();
    checkOutput("midrst tail m_tuser", m_tuser, {96'd0, 32'h0000_0203});
    s_tvalid = 1'b0;
    tick();

    // count wrap from a forced start value
    force dut.stamp_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stamp_cnt;
    checkOutput("wrap preload", pkt_count, 32'hFFFF_FFFF);
    stamp_en = 1'b1;
    applyStimulus({8{32'h5000_0000}}, {96'd0, 32'h0000_0300}, 1'b1);
    tick();
    checkOutput("wrap count", pkt_count, 0);
    s_tvalid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
